// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encoding shared by the ALU and the execute stage.
// Exports alu_op_e (RV32I integer register/immediate operations).
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

endpackage

// File: rtl/ex_pkg.sv
// ex_pkg: execute-stage operand select, branch op encodings, insn size.
// Users also import alu_pkg for alu_op_e.
package ex_pkg;

    import alu_pkg::alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1,
        OPA_PC,
        OPA_ZERO
    } opa_sel_e;

    typedef enum logic {
        OPB_RS2,
        OPB_IMM
    } opb_sel_e;

    typedef enum logic [3:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU,
        BR_JAL,
        BR_JALR
    } br_op_e;

    localparam int INSN_BYTES = 4;

endpackage

// File: rtl/alu.sv
// alu: combinational RV32I integer ALU.
// Ports: op, a, b in; y result, cmp_eq/cmp_lt/cmp_ltu compare flags of a vs b.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e           op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   y,
    output logic              cmp_eq,
    output logic              cmp_lt,
    output logic              cmp_ltu
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt   = b[SHW-1:0];
    assign cmp_eq  = (a == b);
    assign cmp_lt  = ($signed(a) < $signed(b));
    assign cmp_ltu = (a < b);

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, cmp_lt};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, cmp_ltu};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: RV32I execute; operand select, ALU, branch resolve, output slot.
// Ports: clk/rst(sync high)/flush; in_* decode handshake+fields; out_* memory
// handshake+fields; redirect_valid/redirect_pc fetch redirect pulse.
// Option: EX_MISALIGN_CHECK_EN flags misaligned taken targets via out_exc.
module execute_stage
    import alu_pkg::*;
    import ex_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  alu_op_e         in_alu_op,
    input  opa_sel_e        in_a_sel,
    input  opb_sel_e        in_b_sel,
    input  br_op_e          in_br_op,
    input  logic [4:0]      in_rd,
    input  logic            in_wb_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic            out_exc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_y;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic            is_jump;
    logic            taken;
    logic            exc;
    logic            accept;

    always_comb begin
        op_a = '0;
        unique case (in_a_sel)
            OPA_RS1:  op_a = in_rs1;
            OPA_PC:   op_a = in_pc;
            OPA_ZERO: op_a = '0;
            default:  op_a = '0;
        endcase
    end

    assign op_b = (in_b_sel == OPB_IMM) ? in_imm : in_rs2;

    alu #(
        .XLEN    (XLEN)
    ) u_alu (
        .op      (in_alu_op),
        .a       (op_a),
        .b       (op_b),
        .y       (alu_y),
        .cmp_eq  (cmp_eq),
        .cmp_lt  (cmp_lt),
        .cmp_ltu (cmp_ltu)
    );

    // Link address and targets use their own adders so the ALU stays free.
    assign link     = in_pc + XLEN'(INSN_BYTES);
    assign br_tgt   = in_pc + in_imm;
    assign jalr_sum = in_rs1 + in_imm;

    assign is_jump = (in_br_op == BR_JAL) || (in_br_op == BR_JALR);
    assign target  = (in_br_op == BR_JALR)
                   ? {jalr_sum[XLEN-1:1], 1'b0}
                   : br_tgt;
    assign result  = is_jump ? link : alu_y;

    always_comb begin
        taken = 1'b0;
        unique case (in_br_op)
            BR_NONE: taken = 1'b0;
            BR_EQ:   taken = cmp_eq;
            BR_NE:   taken = !cmp_eq;
            BR_LT:   taken = cmp_lt;
            BR_GE:   taken = !cmp_lt;
            BR_LTU:  taken = cmp_ltu;
            BR_GEU:  taken = !cmp_ltu;
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

`ifdef EX_MISALIGN_CHECK_EN
    assign exc = taken && (target[1:0] != 2'b00);
`else
    assign exc = 1'b0;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // redirect_valid defaults low every cycle so it pulses once per
    // accepted taken transfer, independent of downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store      <= '0;
            out_pc         <= RESET_PC;
            out_rd         <= '0;
            out_wb_en      <= 1'b0;
            out_exc        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            redirect_valid <= 1'b0;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid      <= 1'b1;
                out_result     <= result;
                out_store      <= in_rs2;
                out_pc         <= in_pc;
                out_rd         <= in_rd;
                out_wb_en      <= in_wb_en && !exc;
                out_exc        <= exc;
                redirect_valid <= taken && !exc;
                if (taken) begin
                    redirect_pc <= target;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed table, corner sequences and random run
// against a behavioural model of the execute stage.
module tb_execute_stage;

    import alu_pkg::*;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    alu_op_e     in_alu_op;
    opa_sel_e    in_a_sel;
    opb_sel_e    in_b_sel;
    br_op_e      in_br_op;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_store, out_pc;
    logic [4:0]  out_rd;
    logic        out_wb_en, out_exc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_br_op(in_br_op), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store(out_store), .out_pc(out_pc),
        .out_rd(out_rd), .out_wb_en(out_wb_en), .out_exc(out_exc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        alu_op_e     op;
        opa_sel_e    a;
        opb_sel_e    b;
        br_op_e      br;
        logic [31:0] pc, rs1, rs2, imm;
        logic [31:0] e_res;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_exc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(alu_op_e op, opa_sel_e a, opb_sel_e b,
                                br_op_e br, logic [31:0] pc,
                                logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic [31:0] res,
                                logic rd, logic [31:0] rpc, logic ex);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.br = br;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.e_res = res; v.e_redir = rd; v.e_rpc = rpc; v.e_exc = ex;
        return v;
    endfunction

    task automatic drive(alu_op_e op, opa_sel_e a, opb_sel_e b,
                         br_op_e br, logic [31:0] pc, logic [31:0] rs1,
                         logic [31:0] rs2, logic [31:0] imm);
        in_alu_op = op; in_a_sel = a; in_b_sel = b; in_br_op = br;
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_rd = 5'd7; in_wb_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_redir_valid"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_result"}, out_result, 32'd0);
        chk({tag, "_store"}, out_store, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_wb_en"}, 32'(out_wb_en), 32'd0);
        chk({tag, "_exc"}, 32'(out_exc), 32'd0);
        chk({tag, "_redir_pc"}, redirect_pc, 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Reference semantics of RV32I execute, from the ISA rules.
    function automatic logic [31:0] ref_alu(alu_op_e op, logic [31:0] a,
                                            logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(br_op_e br, logic [31:0] x,
                                       logic [31:0] y);
        case (br)
            BR_EQ:   return x == y;
            BR_NE:   return x != y;
            BR_LT:   return $signed(x) < $signed(y);
            BR_GE:   return $signed(x) >= $signed(y);
            BR_LTU:  return x < y;
            BR_GEU:  return x >= y;
            BR_JAL:  return 1'b1;
            BR_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // model slot
    logic        m_valid, m_rv, m_wb, m_exc;
    logic [31:0] m_res, m_store, m_pc, m_rpc;
    logic [4:0]  m_rd;

    initial begin
        logic [31:0] a, b, tgt;
        logic        tk, ex, acc, rdy;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 0, 0, 0, 0);
        repeat (2) tick();
        chk_reset("reset");
        rst = 1'b0;

        vecs[0]  = mk(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 32'h0, 5, 7, 0,
                      12, 0, 0, 0);
        vecs[1]  = mk(ALU_ADD, OPA_RS1, OPB_RS2, BR_LT, 32'h100,
                      32'hFFFF_FFFF, 1, 32'h20, 0, 1, 32'h120, 0);
        vecs[2]  = mk(ALU_ADD, OPA_RS1, OPB_RS2, BR_LTU, 32'h100,
                      32'hFFFF_FFFF, 1, 32'h20, 0, 0, 0, 0);
`ifdef EX_MISALIGN_CHECK_EN
        vecs[3]  = mk(ALU_ADD, OPA_RS1, OPB_IMM, BR_JALR, 32'h40,
                      32'h203, 0, 0, 32'h44, 0, 32'h202, 1);
`else
        vecs[3]  = mk(ALU_ADD, OPA_RS1, OPB_IMM, BR_JALR, 32'h40,
                      32'h203, 0, 0, 32'h44, 1, 32'h202, 0);
`endif
        vecs[4]  = mk(ALU_SUB, OPA_RS1, OPB_RS2, BR_NONE, 32'h4, 10, 3, 0,
                      7, 0, 0, 0);
        vecs[5]  = mk(ALU_ADD, OPA_PC, OPB_IMM, BR_JAL, 32'h1000, 0, 0,
                      32'hFFFF_FF00, 32'h1004, 1, 32'hF00, 0);
        vecs[6]  = mk(ALU_ADD, OPA_ZERO, OPB_IMM, BR_NONE, 32'h8, 9, 9,
                      32'h1234_5000, 32'h1234_5000, 0, 0, 0);
        vecs[7]  = mk(ALU_ADD, OPA_PC, OPB_IMM, BR_NONE, 32'h8000, 0, 0,
                      32'h1000, 32'h9000, 0, 0, 0);
        vecs[8]  = mk(ALU_ADD, OPA_RS1, OPB_RS2, BR_GE, 32'h300,
                      32'hFFFF_FFFD, 32'hFFFF_FFFD, 8, 32'hFFFF_FFFA, 1,
                      32'h308, 0);
        vecs[9]  = mk(ALU_ADD, OPA_RS1, OPB_RS2, BR_NE, 32'h10, 4, 4, 8,
                      8, 0, 0, 0);
        vecs[10] = mk(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 32'h14,
                      32'hFFFF_FFFF, 2, 0, 1, 0, 0, 0);
        vecs[11] = mk(ALU_SRA, OPA_RS1, OPB_RS2, BR_NONE, 32'h18,
                      32'h8000_0000, 4, 0, 32'hF800_0000, 0, 0, 0);
        vecs[12] = mk(ALU_SLT, OPA_RS1, OPB_RS2, BR_NONE, 32'h1C,
                      32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0);
        vecs[13] = mk(ALU_SLTU, OPA_RS1, OPB_RS2, BR_NONE, 32'h20,
                      32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
        vecs[14] = mk(ALU_ADD, OPA_RS1, OPB_RS2, BR_GEU, 32'h24, 1,
                      32'hFFFF_FFFF, 8, 0, 0, 0, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].br, vecs[i].pc,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            in_valid = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), out_result, vecs[i].e_res);
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("vec%0d_store", i), out_store, vecs[i].rs2);
            chk($sformatf("vec%0d_redir", i), 32'(redirect_valid),
                32'(vecs[i].e_redir));
            chk($sformatf("vec%0d_exc", i), 32'(out_exc),
                32'(vecs[i].e_exc));
            chk($sformatf("vec%0d_wb", i), 32'(out_wb_en),
                32'(!vecs[i].e_exc));
            if (vecs[i].e_redir || vecs[i].e_exc)
                chk($sformatf("vec%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // taken BEQ then downstream stall for 3 cycles
        drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_EQ, 32'h200, 9, 9, 32'h10);
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 32'h204, 1, 1, 0);
        #1;
        chk("beq_redir", 32'(redirect_valid), 32'd1);
        chk("beq_rpc", redirect_pc, 32'h210);
        chk("beq_result", out_result, 32'd18);
        chk("beq_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_redir", i), 32'(redirect_valid), 32'd0);
            chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_result", i), out_result, 32'd18);
            chk($sformatf("stall%0d_pc", i), out_pc, 32'h200);
            chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_result", out_result, 32'd2);
        chk("release_pc", out_pc, 32'h204);
        chk("release_redir", 32'(redirect_valid), 32'd0);
        in_valid = 1'b0;
        tick();

        // flush with slot full and a SUB presented
        out_ready = 1'b0;
        drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 32'h300, 3, 4, 0);
        in_valid = 1'b1;
        tick();
        chk("fl_fill_valid", 32'(out_valid), 32'd1);
        chk("fl_fill_result", out_result, 32'd7);
        drive(ALU_SUB, OPA_RS1, OPB_RS2, BR_NONE, 32'h304, 9, 2, 0);
        flush = 1'b1;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_after_valid", 32'(out_valid), 32'd0);
        chk("fl_after_result", out_result, 32'd7);
        chk("fl_after_pc", out_pc, 32'h300);

        // reset during a stall
        out_ready = 1'b0;
        drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_EQ, 32'h400, 5, 5, 32'h40);
        in_valid = 1'b1;
        tick();
        chk("rs_fill_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("midrst");

        // random run against the model
        m_valid = 0; m_rv = 0; m_wb = 0; m_exc = 0;
        m_res = 0; m_store = 0; m_pc = 0; m_rpc = 0; m_rd = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_alu_op = alu_op_e'($urandom_range(0, 9));
            in_br_op  = br_op_e'($urandom_range(0, 8));
            in_a_sel  = opa_sel_e'($urandom_range(0, 2));
            in_b_sel  = opb_sel_e'($urandom_range(0, 1));
            in_pc     = $urandom;
            in_rs1    = ($urandom_range(0, 1) != 0) ? $urandom
                                                    : $urandom_range(0, 8);
            in_rs2    = ($urandom_range(0, 3) == 0) ? in_rs1
                      : (($urandom_range(0, 1) != 0) ? $urandom
                                                     : $urandom_range(0, 8));
            in_imm    = $urandom;
            in_rd     = 5'($urandom);
            in_wb_en  = 1'($urandom);
            if (in_br_op inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU,
                                 BR_GEU}) begin
                in_a_sel = OPA_RS1;
                in_b_sel = OPB_RS2;
            end

            rdy = !m_valid || out_ready;
            acc = in_valid && rdy && !flush;
            a = (in_a_sel == OPA_RS1) ? in_rs1
              : (in_a_sel == OPA_PC) ? in_pc : 32'd0;
            b = (in_b_sel == OPB_IMM) ? in_imm : in_rs2;
            tk  = ref_taken(in_br_op, in_rs1, in_rs2);
            tgt = (in_br_op == BR_JALR) ? ((in_rs1 + in_imm) & ~32'd1)
                                        : (in_pc + in_imm);
`ifdef EX_MISALIGN_CHECK_EN
            ex = tk && (tgt % 4 != 0);
`else
            ex = 1'b0;
`endif
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(rdy));

            m_rv = 1'b0;
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_res   = (in_br_op == BR_JAL || in_br_op == BR_JALR)
                        ? in_pc + 4 : ref_alu(in_alu_op, a, b);
                m_store = in_rs2;
                m_pc    = in_pc;
                m_rd    = in_rd;
                m_wb    = in_wb_en && !ex;
                m_exc   = ex;
                m_rv    = tk && !ex;
                if (tk) m_rpc = tgt;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end

            tick();
            chk("rnd_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd_redir", 32'(redirect_valid), 32'(m_rv));
            chk("rnd_rpc", redirect_pc, m_rpc);
            chk("rnd_result", out_result, m_res);
            chk("rnd_store", out_store, m_store);
            chk("rnd_pc", out_pc, m_pc);
            chk("rnd_rd", 32'(out_rd), 32'(m_rd));
            chk("rnd_wb", 32'(out_wb_en), 32'(m_wb));
            chk("rnd_exc", 32'(out_exc), 32'(m_exc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Single-cycle RV32I execute stage between decode and memory access. Selects ALU operands, instantiates `alu`, resolves conditional branches and jumps, and registers the result into a valid/ready output slot. Issues a one-cycle redirect pulse to fetch for every taken control transfer and honours a synchronous flush from the hazard unit.

## Interface
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, reset value of the `redirect_pc` and `out_pc` registers.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of the output slot and of any same-cycle input.
- `in_valid` / `in_ready`  in / out  1 / 1  decode handshake.
- `in_pc`, `in_rs1`, `in_rs2`, `in_imm`  in  XLEN each  instruction PC, register operands, sign-extended immediate.
- `in_alu_op`  in  `alu_op_e`  ALU operation.
- `in_a_sel`  in  `opa_sel_e`  ALU A source: `OPA_RS1`, `OPA_PC`, `OPA_ZERO`.
- `in_b_sel`  in  `opb_sel_e`  ALU B source: `OPB_RS2`, `OPB_IMM`.
- `in_br_op`  in  `br_op_e`  `BR_NONE`, `BR_EQ`, `BR_NE`, `BR_LT`, `BR_GE`, `BR_LTU`, `BR_GEU`, `BR_JAL`, `BR_JALR`.
- `in_rd`  in  5  destination register; `in_wb_en`  in  1  writeback enable.
- `out_valid` / `out_ready`  out / in  1 / 1  memory-stage handshake.
- `out_result`, `out_store`, `out_pc`  out  XLEN each  result, `rs2` pass-through, instruction PC.
- `out_rd`  out  5; `out_wb_en`  out  1; `out_exc`  out  1  misaligned-target flag.
- `redirect_valid`  out  1  one-cycle pulse; `redirect_pc`  out  XLEN  redirect target.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`.
- Result:
  - `BR_JAL` / `BR_JALR`: `in_pc + 4`, computed on a dedicated adder.
  - Otherwise: ALU `y`.
- Branch compare uses the ALU `cmp_eq`/`cmp_lt`/`cmp_ltu` flags with `a = in_rs1`, `b = in_rs2`. Decode supplies `OPA_RS1` and `OPB_RS2` for conditional branches.
- Branch decisions:
  - `BR_GE` = `!cmp_lt`; `BR_GEU` = `!cmp_ltu`; `BR_NE` = `!cmp_eq`.
  - `BR_JAL` and `BR_JALR` are always taken.
- Targets:
  - Conditional branches and `BR_JAL`: `in_pc + in_imm`, on a dedicated adder.
  - `BR_JALR`: `(in_rs1 + in_imm) & ~1`.
- All additions are modulo 2^XLEN; wrap-around is silent.
- On accept of a taken transfer, register `redirect_pc` and assert `redirect_valid` for exactly the next cycle. It asserts once, regardless of any `out_ready` stall.
- `flush` has priority over accept:
  - clears `out_valid` and `redirect_valid` next cycle;
  - discards an instruction presented in the same cycle;
  - `in_ready` still follows the formula above.
- When `out_valid && !out_ready`, all `out_*` fields hold stable.

## Timing
- Latency 1 cycle: accept at edge N, so `out_valid` and `redirect_valid` are high after edge N.
- Throughput 1 instruction/cycle while `out_ready` is held high.
- Simultaneous pop and push: the slot is replaced in the same edge, with no bubble.
- Reset values:
  - `out_valid`, `redirect_valid`, `out_exc`, `out_wb_en` = 0.
  - `out_result`, `out_store`, `out_rd` = 0.
  - `out_pc`, `redirect_pc` = `RESET_PC`.
- Reset mid-stall drops the held instruction.

## Configuration
- `EX_MISALIGN_CHECK_EN` defined:
  - A taken target with `target[1:0] != 0` sets `out_exc = 1`, forces `out_wb_en = 0`, and suppresses `redirect_valid`.
  - `redirect_pc` still captures the target for the trap handler.
- Undefined: `out_exc` is tied 0 and redirects are issued unconditionally.

## Structure
- Shared package `ex_pkg` holds `opa_sel_e`, `opb_sel_e`, `br_op_e`, and `localparam INSN_BYTES = 4`.
- `ex_pkg` imports `alu_pkg::alu_op_e`.
- One sub-module: `alu` instance `u_alu`. Branch compare, adders and output register stay inline.

## Test plan
- ADD with `rs1=5`, `rs2=7`, `OPB_RS2`, `out_ready=1` -> next cycle `out_valid=1`, `out_result=12`, `redirect_valid=0`.
- BLT with `rs1=32'hFFFF_FFFF`, `rs2=1`, `pc=32'h100`, `imm=32'h20` -> `redirect_valid` pulses 1 cycle, `redirect_pc=32'h120`; BLTU with the same operands is not taken.
- JALR with `rs1=32'h203`, `imm=0`, `pc=32'h40`, macro undefined -> `out_result=32'h44`, `redirect_pc=32'h202`. With the macro defined -> `out_exc=1`, no redirect.
- `out_ready=0` for 3 cycles after a taken BEQ -> `out_*` stable, `in_ready=0`, `redirect_valid` high for exactly 1 cycle.
- `flush` in the same cycle as an `in_valid` SUB with the slot full -> next cycle `out_valid=0` and the SUB never appears.
- `rst` asserted while `out_valid=1` stalled -> next cycle all outputs at reset values and `in_ready=1`.
